sram_port_arb: RTL and testbench
================================

# sram_port_arb

Round-robin arbiter sharing one single-port OpenRAM-style SRAM macro (active-low `csb`/`web`, byte `wmask`, clocked on the inverted system clock) among `NumReq` requesters. Typical requesters are the ICCM programming controller, the TL-UL instruction adapter and the debug system-bus path. It sits between the memory adapters and the `sram` macro. It replaces direct adapter-to-macro wiring so the programmer can load the ICCM while fetch traffic is held off. The arbiter issues one access per cycle and returns a per-requester response pulse.

## Interface
- `NumReq`, default 3: number of requesters. Index 0 is the lockable requester.
- `AddrWidth`, default 12: word address width at the requesters.
- `DataWidth`, default 32: data width. `DataWidth/8` mask bits.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `lock_i`  in  1  when high, only requester 0 may be granted (programming mode).
- `req_i`  in  NumReq  access request, one bit per requester.
- `we_i`  in  NumReq  1 = write, 0 = read.
- `addr_i`  in  NumReq×AddrWidth  word address per requester.
- `wdata_i`  in  NumReq×DataWidth  write data per requester.
- `wmask_i`  in  NumReq×DataWidth/8  byte write mask per requester.
- `gnt_o`  out  NumReq  one-hot grant, combinational, same cycle as the request.
- `rsp_valid_o`  out  NumReq  one-hot response pulse, one cycle after the grant.
- `rdata_o`  out  DataWidth  read data. Valid while `rsp_valid_o` is nonzero for a read.
- `csb_o`  out  1  SRAM chip select, active-low.
- `web_o`  out  1  SRAM write enable, active-low.
- `wmask_o`  out  DataWidth/8  SRAM write mask.
- `addr_o`  out  AddrWidth  SRAM address.
- `wdata_o`  out  DataWidth  SRAM write data.
- `rdata_i`  in  DataWidth  SRAM read data.

## Operation
- Eligible set = `req_i`. While `lock_i` = 1, eligible set = `req_i & 1`.
- Grant: the first eligible index at or after `ptr_q`, searched cyclically. Nothing eligible → `gnt_o` = 0.
- After any grant of index k, `ptr_q` ← (k+1) mod NumReq, wrapping at NumReq-1 → 0. With no grant, `ptr_q` holds.
- SRAM outputs carry the granted requester's fields.
  - `csb_o` = 0 when any grant, else 1.
  - `web_o` = ~`we_i[k]`.
  - No grant → `web_o` = 1 and `wmask_o`, `addr_o`, `wdata_o` = 0.
- Response tracking:
  - Register `rsp_q` = `gnt_o`, so `rsp_valid_o` = `rsp_q`.
  - Register `rsp_we_q` = the granted request's `we` bit.
  - Every granted request gets exactly one response pulse. Writes also pulse, as an ack for the TL-UL `d_valid`.
- `rdata_o` = `rdata_i` when `rsp_q` ≠ 0 and `rsp_we_q` = 0, else 0.
- Requesters must hold `req_i`, `addr_i` and data stable until granted.
- Requesters may issue back-to-back: a new request in the response cycle is legal. Throughput is one access per cycle.
- `lock_i` rising while a read response is pending: that response still completes next cycle.
- `lock_i` is not registered. It takes effect on the grant in the same cycle.

## Timing
- Reset values: `ptr_q` = 0, `rsp_q` = 0, `rsp_we_q` = 0.
  - While `rst_ni` = 0, `gnt_o` is forced to 0, so `csb_o` = 1 and `web_o` = 1.
  - `rsp_valid_o` = 0 and `rdata_o` = 0.
- Grant latency 0 cycles. Response latency 1 cycle after the grant edge.
- The macro samples on the falling edge of `clk_i`. `rdata_i` is stable before the next rising edge.
- No state machine beyond `ptr_q`/`rsp_q`. Total flops: log2(NumReq) + NumReq + 1.
- Reset asserted mid-access: the pending response is dropped, with no pulse after reset release.
- Simultaneous requests: exactly one grant per cycle. `gnt_o` is never more than one-hot.
- An asserted assertion-checker must flag `gnt_o` not one-hot, and `rsp_valid_o` without a grant in the previous cycle.

## Structure
- Shared `sram_arb_pkg`:
  - `NumReqDefault`.
  - Typedef `sram_req_t` (`we`, `addr`, `wdata`, `wmask`).
  - Typedef `sram_rsp_t` (`valid`, `rdata`).
- Sub-module `rr_arb` (parameter `N`): inputs `req`, `ptr`. Outputs one-hot `gnt` and `gnt_idx`.
  - Implement as a double-width masked priority encoder.
  - Combinational only. `sram_port_arb` owns all flops.

## Test plan
- Reset → `csb_o` = 1, `web_o` = 1, `gnt_o` = 0, `rsp_valid_o` = 0 while `rst_ni` low, even with `req_i` = 3'b111.
- Requester 1 writes `addr` 0x004, data 0xDEADBEEF, mask 4'hF; next cycle requester 2 reads 0x004.
  - `gnt_o` = 3'b010, then 3'b100.
  - `rsp_valid_o` = 3'b010, then 3'b100 with `rdata_o` = 0xDEADBEEF.
- `req_i` = 3'b111 held 6 cycles from reset → grants 0,1,2,0,1,2. `ptr_q` wraps 2 → 0.
- `lock_i` = 1, `req_i` = 3'b110 → `gnt_o` = 0 for 4 cycles. Add `req_i[0]` → `gnt_o` = 3'b001 the same cycle.
- Read by requester 2 granted, `lock_i` rises the next cycle → `rsp_valid_o` = 3'b100 with valid `rdata_o`, then only requester 0 is granted.
- Read granted, `rst_ni` pulsed low before the next edge → no `rsp_valid_o` pulse, `ptr_q` = 0 after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared definitions for the SRAM port arbiter slice.
//   NumReqDefault        default number of requesters sharing the macro
//   AddrWidthDefault     default word address width
//   DataWidthDefault     default data width
//   sram_req_t           one requester's access fields
//   sram_rsp_t           one requester's response fields
//   idx_width()          width of an index into n requesters (at least 1)
package sram_arb_pkg;

  localparam int NumReqDefault    = 3;
  localparam int AddrWidthDefault = 12;
  localparam int DataWidthDefault = 32;

  typedef struct packed {
    logic                          we;
    logic [AddrWidthDefault-1:0]   addr;
    logic [DataWidthDefault-1:0]   wdata;
    logic [DataWidthDefault/8-1:0] wmask;
  } sram_req_t;

  typedef struct packed {
    logic                        valid;
    logic [DataWidthDefault-1:0] rdata;
  } sram_rsp_t;

  // A single requester still needs a one-bit index so port widths stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arb_chk.sv
// sram_port_arb_chk: protocol checker for sram_port_arb.
//   clk_i, rst_ni  in  clock and asynchronous active-low reset
//   gnt_o          in  NumReq  grant vector to watch
//   rsp_valid_o    in  NumReq  response vector to watch
// Flags a grant that is not at most one-hot, and a response pulse on a
// requester that was not granted in the previous cycle.
module sram_port_arb_chk
  import sram_arb_pkg::*;
#(
  parameter int NumReq = NumReqDefault
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic [NumReq-1:0] gnt_o,
  input logic [NumReq-1:0] rsp_valid_o
);

  logic [NumReq-1:0] gnt_prev_r;

  // Remember last cycle's grant to validate this cycle's response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_prev_r <= {NumReq{1'b0}};
    end else begin
      gnt_prev_r <= gnt_o;
    end
  end

  // Sample both properties on the rising edge outside reset.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(gnt_o));
      assert ((rsp_valid_o & ~gnt_prev_r) == {NumReq{1'b0}});
    end else begin
    end
  end

endmodule

// File: rtl/sram_port_arb_rr_arb.sv
// rr_arb: combinational round-robin grant selection.
//   req      in   N   request vector (already filtered for eligibility)
//   ptr      in   IW  index with the highest priority this cycle
//   gnt      out  N   one-hot grant, zero when nothing is requested
//   gnt_idx  out  IW  index of the granted bit (0 when nothing granted)
// The request vector is duplicated to 2N bits and everything below ptr is
// masked off; the lowest remaining bit is the first requester at or after
// ptr in cyclic order, and its position modulo N is the grant index.
module rr_arb
  import sram_arb_pkg::*;
#(
  parameter  int N  = NumReqDefault,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [2*N-1:0] masked_s;
  logic           found_s;
  logic [IW-1:0]  idx_s;

  // Mask off the duplicated request bits below the priority pointer.
  always_comb begin
    masked_s = {req, req};
    for (int j = 0; j < 2 * N; j++) begin
      if (j < int'(ptr)) begin
        masked_s[j] = 1'b0;
      end else begin
        masked_s[j] = masked_s[j];
      end
    end
  end

  // Priority-encode the lowest set bit of the masked vector.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {IW{1'b0}};
    for (int j = 0; j < 2 * N; j++) begin
      if (masked_s[j] && !found_s) begin
        found_s = 1'b1;
        idx_s   = IW'(j % N);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Expand the encoded index back to a one-hot grant.
  always_comb begin
    gnt_idx = idx_s;
    if (found_s) begin
      gnt = {{(N-1){1'b0}}, 1'b1} << idx_s;
    end else begin
      gnt = {N{1'b0}};
    end
  end

endmodule

// File: rtl/sram_port_arb.sv
// sram_port_arb: round-robin sharing of one single-port SRAM macro.
//   clk_i        in   1       system clock (macro runs on its falling edge)
//   rst_ni       in   1       asynchronous active-low reset
//   lock_i       in   1       restrict grants to requester 0
//   req_i        in   NumReq  request per requester
//   we_i         in   NumReq  1 = write, 0 = read
//   addr_i       in   NumReq*AddrWidth   word address per requester
//   wdata_i      in   NumReq*DataWidth   write data per requester
//   wmask_i      in   NumReq*DataWidth/8 byte mask per requester
//   gnt_o        out  NumReq  one-hot grant, same cycle as the request
//   rsp_valid_o  out  NumReq  one-hot response pulse, one cycle after grant
//   rdata_o      out  DataWidth read data during a read response, else 0
//   csb_o/web_o  out  1       macro chip select / write enable, active-low
//   wmask_o, addr_o, wdata_o  out  macro fields of the granted requester
//   rdata_i      in   DataWidth macro read data
module sram_port_arb
  import sram_arb_pkg::*;
#(
  parameter int NumReq    = NumReqDefault,
  parameter int AddrWidth = 12,
  parameter int DataWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          lock_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] wmask_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          csb_o,
  output logic                          web_o,
  output logic [DataWidth/8-1:0]        wmask_o,
  output logic [AddrWidth-1:0]          addr_o,
  output logic [DataWidth-1:0]          wdata_o,
  input  logic [DataWidth-1:0]          rdata_i
);

  localparam int IW = idx_width(NumReq);
  localparam int MW = DataWidth / 8;

  logic [NumReq-1:0] elig_s;
  logic [NumReq-1:0] arb_gnt_s;
  logic [NumReq-1:0] gnt_s;
  logic [IW-1:0]     gnt_idx_s;
  logic              we_sel_s;

  logic [IW-1:0]     ptr_r;
  logic [NumReq-1:0] rsp_r;
  logic              rsp_we_r;

  // Programming mode leaves only requester 0 eligible.
  always_comb begin
    if (lock_i) begin
      elig_s = req_i & {{(NumReq-1){1'b0}}, 1'b1};
    end else begin
      elig_s = req_i;
    end
  end

  rr_arb #(.N(NumReq)) u_rr_arb (
    .req     (elig_s),
    .ptr     (ptr_r),
    .gnt     (arb_gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // No grant may reach the macro while reset is held.
  always_comb begin
    if (rst_ni) begin
      gnt_s = arb_gnt_s;
    end else begin
      gnt_s = {NumReq{1'b0}};
    end
  end

  assign gnt_o = gnt_s;

  // Steer the granted requester's fields onto the macro; idle drives zeros.
  always_comb begin
    csb_o    = 1'b1;
    web_o    = 1'b1;
    we_sel_s = 1'b0;
    wmask_o  = {MW{1'b0}};
    addr_o   = {AddrWidth{1'b0}};
    wdata_o  = {DataWidth{1'b0}};
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_s[i]) begin
        csb_o    = 1'b0;
        web_o    = ~we_i[i];
        we_sel_s = we_i[i];
        wmask_o  = wmask_i[i*MW +: MW];
        addr_o   = addr_i[i*AddrWidth +: AddrWidth];
        wdata_o  = wdata_i[i*DataWidth +: DataWidth];
      end else begin
        csb_o = csb_o;
      end
    end
  end

  // Round-robin pointer: advance past the granted index, hold when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_r <= {IW{1'b0}};
    end else if (|gnt_s) begin
      if (gnt_idx_s == IW'(NumReq - 1)) begin
        ptr_r <= {IW{1'b0}};
      end else begin
        ptr_r <= gnt_idx_s + IW'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Response tracking: every grant yields exactly one pulse next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_r    <= {NumReq{1'b0}};
      rsp_we_r <= 1'b0;
    end else begin
      rsp_r    <= gnt_s;
      rsp_we_r <= we_sel_s;
    end
  end

  assign rsp_valid_o = rsp_r;

  // Read data is only forwarded during a read response.
  always_comb begin
    if ((|rsp_r) && !rsp_we_r) begin
      rdata_o = rdata_i;
    end else begin
      rdata_o = {DataWidth{1'b0}};
    end
  end

endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: directed bench for sram_port_arb with a behavioural
// falling-edge SRAM macro and a protocol checker alongside.
module tb_sram_port_arb;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        lock;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [35:0] addr;
  logic [95:0] wdata;
  logic [11:0] wmask;
  logic [2:0]  gnt;
  logic [2:0]  rsp_valid;
  logic [31:0] rdata;
  logic        csb;
  logic        web;
  logic [3:0]  wmask_m;
  logic [11:0] addr_m;
  logic [31:0] wdata_m;
  logic [31:0] rdata_m;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  sram_port_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .lock_i      (lock),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .wmask_i     (wmask),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid),
    .rdata_o     (rdata),
    .csb_o       (csb),
    .web_o       (web),
    .wmask_o     (wmask_m),
    .addr_o      (addr_m),
    .wdata_o     (wdata_m),
    .rdata_i     (rdata_m)
  );

  sram_port_arb_chk #(.NumReq(3)) u_chk (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid)
  );

  // Behavioural macro: samples on the falling edge, byte-masked writes.
  always @(negedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask_m[b]) mem[addr_m][b*8 +: 8] <= wdata_m[b*8 +: 8];
        end
      end else begin
        rdata_m <= mem[addr_m];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 32'h0000_0000;
    rdata_m = 32'h0000_0000;
    rst_ni  = 1'b0;
    lock    = 1'b0;
    req     = 3'b111;
    we      = 3'b000;
    addr    = {12'h030, 12'h020, 12'h010};
    wdata   = 96'h0;
    wmask   = 12'h000;

    // Reset held with all requesters asking.
    tick();
    tick();
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_csb", 32'(csb), 32'h1);
    chk("rst_web", 32'(web), 32'h1);
    chk("rst_rsp", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    // Release with all requesters asking: grants rotate 0,1,2,0,1,2.
    tick();
    rst_ni = 1'b1;
    #1;
    chk("rr_gnt0", 32'(gnt), 32'h1);
    chk("rr_rsp0", 32'(rsp_valid), 32'h0);
    chk("rr_addr0", 32'(addr_m), 32'h010);
    for (int i = 1; i < 6; i++) begin
      tick();
      #1;
      chk("rr_gnt", 32'(gnt), 32'(3'b001 << (i % 3)));
      chk("rr_rsp", 32'(rsp_valid), 32'(3'b001 << ((i - 1) % 3)));
    end

    // Requester 1 writes 0x004, then requester 2 reads it back.
    tick();
    req   = 3'b010;
    we    = 3'b010;
    addr  = {12'h030, 12'h004, 12'h010};
    wdata = {32'h0, 32'hDEADBEEF, 32'h0};
    wmask = {4'h0, 4'hF, 4'h0};
    #1;
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_csb", 32'(csb), 32'h0);
    chk("wr_web", 32'(web), 32'h0);
    chk("wr_addr", 32'(addr_m), 32'h004);
    chk("wr_wdata", wdata_m, 32'hDEADBEEF);
    chk("wr_wmask", 32'(wmask_m), 32'hF);
    chk("wr_rsp_prev", 32'(rsp_valid), 32'h4);
    tick();
    req  = 3'b100;
    we   = 3'b000;
    addr = {12'h004, 12'h004, 12'h010};
    #1;
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_web", 32'(web), 32'h1);
    chk("wr_rsp", 32'(rsp_valid), 32'h2);
    chk("wr_rdata_zero", rdata, 32'h0);
    tick();
    req = 3'b000;
    #1;
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_csb", 32'(csb), 32'h1);
    chk("idle_web", 32'(web), 32'h1);
    chk("idle_addr", 32'(addr_m), 32'h0);
    chk("idle_wdata", wdata_m, 32'h0);
    chk("idle_wmask", 32'(wmask_m), 32'h0);
    chk("rd_rsp", 32'(rsp_valid), 32'h4);
    chk("rd_rdata", rdata, 32'hDEADBEEF);

    // Lock with only requesters 1 and 2 asking: nothing granted.
    for (int i = 0; i < 4; i++) begin
      tick();
      lock = 1'b1;
      req  = 3'b110;
      #1;
      chk("lock_gnt", 32'(gnt), 32'h0);
      chk("lock_csb", 32'(csb), 32'h1);
    end
    tick();
    req = 3'b111;
    #1;
    chk("lock_gnt0", 32'(gnt), 32'h1);

    // Read by requester 2, lock rises next cycle; response still completes.
    tick();
    lock = 1'b0;
    req  = 3'b100;
    #1;
    chk("pre_lock_gnt", 32'(gnt), 32'h4);
    chk("pre_lock_rsp", 32'(rsp_valid), 32'h1);
    tick();
    lock = 1'b1;
    req  = 3'b111;
    #1;
    chk("lock_rsp", 32'(rsp_valid), 32'h4);
    chk("lock_rdata", rdata, 32'hDEADBEEF);
    chk("lock_gnt_only0", 32'(gnt), 32'h1);
    tick();
    req = 3'b110;
    #1;
    chk("lock_gnt_none", 32'(gnt), 32'h0);
    chk("lock_rsp0", 32'(rsp_valid), 32'h1);

    // Read granted, then reset pulsed before the next edge.
    tick();
    lock = 1'b0;
    req  = 3'b100;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 32'h4);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_gnt_off", 32'(gnt), 32'h0);
    chk("rst_mid_csb", 32'(csb), 32'h1);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'h0);
    tick();
    rst_ni = 1'b1;
    req    = 3'b000;
    #1;
    chk("rst_rel_rsp", 32'(rsp_valid), 32'h0);
    chk("rst_rel_rdata", rdata, 32'h0);
    tick();
    req = 3'b111;
    #1;
    chk("rst_rel_ptr", 32'(gnt), 32'h1);
    chk("rst_rel_rsp2", 32'(rsp_valid), 32'h0);
    tick();
    req = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
